// File: rtl/pkt_fifo_pkg.sv
// Shared constants and helpers for the multi-channel packet FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pkt_fifo_pkg;

  // Control byte position inside a 72-bit payload word.
  localparam int CTRL_MSB = 71;
  localparam int CTRL_LSB = 64;

  // The RAM word is one bit wider than the payload; the top bit is EOP.
  function automatic int eop_idx(input int dwidth);
    return dwidth;
  endfunction

  // Pointer width: address bits plus one wrap bit to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pkt_fifo_ptr.sv
// One channel's write/commit/read pointers, overflow tracking and status flags.
// Latency: pointers update on the clock edge; flags are combinational from registered pointers.
// Backpressure: writes are refused while full (packet then dropped at EOP); reads of an empty channel are ignored.
module pkt_fifo_ptr
  import pkt_fifo_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int ALM_FULL = 240,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_wr,
  input  logic          i_eop,
  input  logic          i_abort,
  input  logic          i_rd,
  output logic          o_wr_acc,
  output logic          o_rd_acc,
  output logic [AW-1:0] o_wr_addr,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_full,
  output logic          o_almfull,
  output logic          o_empty,
`ifdef FIFO_STATS_EN
  output logic [15:0]   o_drop_cnt,
`endif
  output logic          o_ovf
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_tail;
  logic [PW-1:0] r_head;
  logic          r_bad;
  logic          r_ovf;
  logic [PW-1:0] w_occ;
  logic [PW-1:0] w_wr_ptr_inc;
  logic          w_discard;

  // Occupancy counts speculative words too, so an open packet holds its space.
  assign w_occ        = r_wr_ptr - r_head;
  assign w_wr_ptr_inc = r_wr_ptr + PW'(1);
  assign o_full       = (w_occ == PW'(DEPTH));
  assign o_almfull    = (w_occ >= PW'(ALM_FULL));
  assign o_empty      = (r_head == r_tail);
  assign o_ovf        = r_ovf;
  assign o_wr_addr    = r_wr_ptr[AW-1:0];
  assign o_rd_addr    = r_head[AW-1:0];

  // A word is thrown away if the channel is full or its packet is already doomed.
  assign w_discard = r_bad | o_full;
  assign o_wr_acc  = i_wr & ~i_abort & ~w_discard;
  assign o_rd_acc  = i_rd & ~o_empty;

  // Pointer and overflow state; abort takes priority over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_tail   <= '0;
      r_head   <= '0;
      r_bad    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (i_abort) begin
        r_wr_ptr <= r_tail;
        r_bad    <= 1'b0;
      end else if (i_wr) begin
        if (w_discard) begin
          if (i_eop) begin
            // Drop completes at EOP: rewind and start the next packet clean.
            r_wr_ptr <= r_tail;
            r_bad    <= 1'b0;
            r_ovf    <= 1'b1;
          end else begin
            r_bad <= 1'b1;
          end
        end else begin
          r_wr_ptr <= w_wr_ptr_inc;
          if (i_eop) r_tail <= w_wr_ptr_inc;
        end
      end
      if (o_rd_acc) r_head <= r_head + PW'(1);
    end
  end

`ifdef FIFO_STATS_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  // A drop is an overflowed packet reaching EOP, or an abort discarding accepted words.
  assign w_drop = (i_abort & (r_wr_ptr != r_tail)) |
                  (~i_abort & i_wr & i_eop & w_discard);
  assign o_drop_cnt = r_drop_cnt;

  // Saturating per-channel drop counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: rtl/pkt_fifo_mc.sv
// Multi-channel packet FIFO sharing one dual-port RAM; optional FIFO_STATS_EN adds drop counters.
// Latency: read data/valid/eop one cycle after an accepted rd_en; words visible to readers only after EOP commit.
// Backpressure: per-channel full/almfull flags; writes to a full channel drop the packet, empty reads give no valid.
module pkt_fifo_mc
  import pkt_fifo_pkg::*;
#(
  parameter int DWIDTH   = 72,
  parameter int NCH      = 4,
  parameter int DEPTH    = 256,
  parameter int ALM_FULL = 240,
  localparam int CHW     = $clog2(NCH),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_ch,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_eop,
  input  logic              wr_abort,
  input  logic              rd_en,
  input  logic [CHW-1:0]    rd_ch,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_eop,
  output logic [NCH-1:0]    full,
  output logic [NCH-1:0]    almfull,
  output logic [NCH-1:0]    empty,
`ifdef FIFO_STATS_EN
  output logic [NCH*16-1:0] drop_cnt,
`endif
  output logic [NCH-1:0]    ovf
);

  localparam int EOP = eop_idx(DWIDTH);

  logic [NCH-1:0]    w_wr_acc;
  logic [NCH-1:0]    w_rd_acc;
  logic [AW-1:0]     w_wr_addr [NCH];
  logic [AW-1:0]     w_rd_addr [NCH];
  logic              w_wr_sel;
  logic              w_rd_sel;
  logic [CHW+AW-1:0] w_waddr;
  logic [CHW+AW-1:0] w_raddr;
  logic [DWIDTH:0]   w_rd_word;

  logic [DWIDTH:0]   r_mem [NCH*DEPTH];
  logic [DWIDTH-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_eop;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pkt_fifo_ptr #(
      .DEPTH    (DEPTH),
      .ALM_FULL (ALM_FULL)
    ) u_ptr (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_wr       (wr_en & (wr_ch == CHW'(g))),
      .i_eop      (wr_eop),
      .i_abort    (wr_abort & (wr_ch == CHW'(g))),
      .i_rd       (rd_en & (rd_ch == CHW'(g))),
      .o_wr_acc   (w_wr_acc[g]),
      .o_rd_acc   (w_rd_acc[g]),
      .o_wr_addr  (w_wr_addr[g]),
      .o_rd_addr  (w_rd_addr[g]),
      .o_full     (full[g]),
      .o_almfull  (almfull[g]),
      .o_empty    (empty[g]),
`ifdef FIFO_STATS_EN
      .o_drop_cnt (drop_cnt[g*16 +: 16]),
`endif
      .o_ovf      (ovf[g])
    );
  end

  // Channel number forms the upper address bits, so each channel owns a DEPTH region.
  assign w_wr_sel  = w_wr_acc[wr_ch];
  assign w_rd_sel  = w_rd_acc[rd_ch];
  assign w_waddr   = {wr_ch, w_wr_addr[wr_ch]};
  assign w_raddr   = {rd_ch, w_rd_addr[rd_ch]};
  assign w_rd_word = r_mem[w_raddr];

  // RAM write port; EOP is stored alongside the payload. Contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_sel) r_mem[w_waddr] <= {wr_eop, wr_data};
  end

  // Registered read data; only loaded on an accepted read.
  always_ff @(posedge clk) begin
    if (w_rd_sel) r_rd_data <= w_rd_word[DWIDTH-1:0];
  end

  // Read qualifiers; eop is forced low whenever no word is presented.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_eop   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_sel;
      r_rd_eop   <= w_rd_sel & w_rd_word[EOP];
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_eop   = r_rd_eop;

endmodule

// File: tb/tb_pkt_fifo_mc.sv
// Bench for pkt_fifo_mc: queue-based channel model, per-cycle compare, directed and random stimulus.
// Latency: model predicts read outputs one cycle after an accepted rd_en.
// Backpressure: model drops packets that overflow and ignores empty reads.
module tb_pkt_fifo_mc;

  localparam int NCH   = 4;
  localparam int DEPTH = 256;
  localparam int ALM   = 240;
  localparam int DW    = 72;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            wr_en, wr_eop, wr_abort, rd_en;
  logic [1:0]      wr_ch, rd_ch;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   rd_data;
  logic            rd_valid, rd_eop;
  logic [NCH-1:0]  full, almfull, empty, ovf;
`ifdef FIFO_STATS_EN
  logic [NCH*16-1:0] drop_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  pkt_fifo_mc dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .wr_eop   (wr_eop),
    .wr_abort (wr_abort),
    .rd_en    (rd_en),
    .rd_ch    (rd_ch),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_eop   (rd_eop),
    .full     (full),
    .almfull  (almfull),
    .empty    (empty),
`ifdef FIFO_STATS_EN
    .drop_cnt (drop_cnt),
`endif
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Committed words per channel, the open packet per channel, and drop state.
  logic [DW:0] m_com  [NCH][$];
  logic [DW:0] m_pend [NCH][$];
  bit          m_bad  [NCH];
  bit          m_ovf  [NCH];
  int          m_drop [NCH];
  bit          m_rv;
  bit          m_reop;
  logic [DW-1:0] m_rdat;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin : model
    int  wc, rc;
    bit  wfull, rok;
    logic [DW:0] w;
    chk_en = 1'b1;
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_com[c].delete();
        m_pend[c].delete();
        m_bad[c]  = 1'b0;
        m_ovf[c]  = 1'b0;
        m_drop[c] = 0;
      end
      m_rv   = 1'b0;
      m_reop = 1'b0;
    end else begin
      wc    = int'(wr_ch);
      rc    = int'(rd_ch);
      wfull = (m_com[wc].size() + m_pend[wc].size()) == DEPTH;
      rok   = rd_en && (m_com[rc].size() > 0);
      m_rv   = rok;
      m_reop = 1'b0;
      if (rok) begin
        w      = m_com[rc].pop_front();
        m_reop = w[DW];
        m_rdat = w[DW-1:0];
      end
      if (wr_abort) begin
        if (m_pend[wc].size() != 0 && m_drop[wc] < 65535) m_drop[wc]++;
        m_pend[wc].delete();
        m_bad[wc] = 1'b0;
      end else if (wr_en) begin
        if (m_bad[wc] || wfull) begin
          if (wr_eop) begin
            m_pend[wc].delete();
            m_bad[wc] = 1'b0;
            m_ovf[wc] = 1'b1;
            if (m_drop[wc] < 65535) m_drop[wc]++;
          end else begin
            m_bad[wc] = 1'b1;
          end
        end else begin
          m_pend[wc].push_back({wr_eop, wr_data});
          if (wr_eop) begin
            while (m_pend[wc].size() > 0) m_com[wc].push_back(m_pend[wc].pop_front());
          end
        end
      end
    end
  end

  // Compare DUT against model on every falling edge once clocking has begun.
  always @(negedge clk) begin : cmp
    logic [NCH-1:0] ef, ea, ee, eo;
    int occ;
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        occ   = m_com[c].size() + m_pend[c].size();
        ef[c] = (occ == DEPTH);
        ea[c] = (occ >= ALM);
        ee[c] = (m_com[c].size() == 0);
        eo[c] = m_ovf[c];
      end
      check("full",     80'(full),     80'(ef));
      check("almfull",  80'(almfull),  80'(ea));
      check("empty",    80'(empty),    80'(ee));
      check("ovf",      80'(ovf),      80'(eo));
      check("rd_valid", 80'(rd_valid), 80'(m_rv));
      check("rd_eop",   80'(rd_eop),   80'(m_reop));
      if (m_rv) check("rd_data", 80'(rd_data), 80'(m_rdat));
`ifdef FIFO_STATS_EN
      for (int c = 0; c < NCH; c++)
        check("drop_cnt", 80'(drop_cnt[c*16 +: 16]), 80'(m_drop[c]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit we, input int wc, input logic [DW-1:0] wd, input bit weop,
                      input bit ab, input bit re, input int rc);
    @(negedge clk);
    wr_en    = we;
    wr_ch    = 2'(wc);
    wr_data  = wd;
    wr_eop   = weop;
    wr_abort = ab;
    rd_en    = re;
    rd_ch    = 2'(rc);
  endtask

  task automatic idle();
    tick(0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle();
    idle();
    idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  int cnt;

  initial begin
    reset_n = 1'b0;
    wr_en = 0; wr_ch = 0; wr_data = '0; wr_eop = 0; wr_abort = 0; rd_en = 0; rd_ch = 0;

    // Reset state
    do_reset();
    idle();
    check("reset_empty",   80'(empty),    80'(4'hF));
    check("reset_full",    80'(full),     80'(4'h0));
    check("reset_almfull", 80'(almfull),  80'(4'h0));
    check("reset_valid",   80'(rd_valid), 80'(1'b0));

    // 3-word packet on ch1: invisible until EOP, then read back in order
    tick(1, 1, 72'h100, 0, 0, 0, 0);
    tick(1, 1, 72'h101, 0, 0, 0, 0);
    tick(1, 1, 72'h102, 1, 0, 0, 0);
    check("t1_empty_before_eop", 80'(empty[1]), 80'(1'b1));
    idle();
    check("t1_empty_after_eop", 80'(empty[1]), 80'(1'b0));
    tick(0, 0, '0, 0, 0, 1, 1);
    tick(0, 0, '0, 0, 0, 1, 1);
    check("t1_rd0_valid", 80'(rd_valid), 80'(1'b1));
    check("t1_rd0_data",  80'(rd_data),  80'(72'h100));
    tick(0, 0, '0, 0, 0, 1, 1);
    check("t1_rd1_data",  80'(rd_data),  80'(72'h101));
    check("t1_rd1_eop",   80'(rd_eop),   80'(1'b0));
    idle();
    check("t1_rd2_data",  80'(rd_data),  80'(72'h102));
    check("t1_rd2_eop",   80'(rd_eop),   80'(1'b1));
    check("t1_empty_end", 80'(empty[1]), 80'(1'b1));
    idle();
    check("t1_no_valid",  80'(rd_valid), 80'(1'b0));

    // Abort on ch0 rewinds the open packet
    tick(1, 0, 72'h200, 0, 0, 0, 0);
    tick(1, 0, 72'h201, 0, 0, 0, 0);
    tick(1, 0, 72'h202, 1, 1, 0, 0);
    tick(0, 0, '0, 0, 0, 1, 0);
    check("t2_empty", 80'(empty[0]), 80'(1'b1));
    idle();
    check("t2_rd_valid", 80'(rd_valid), 80'(1'b0));

    // Overflow on ch2: almfull at 240 words, full at 256, drop at EOP
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, 2, 72'(i), 0, 0, 0, 0);
      if (i == ALM - 1) check("t3_almfull_239", 80'(almfull[2]), 80'(1'b0));
      if (i == ALM)     check("t3_almfull_240", 80'(almfull[2]), 80'(1'b1));
    end
    for (int i = 0; i < 4; i++) tick(1, 2, 72'hEEE, 0, 0, 0, 0);
    check("t3_full", 80'(full[2]), 80'(1'b1));
    tick(1, 2, 72'hEEF, 1, 0, 0, 0);
    idle();
    check("t3_ovf",    80'(ovf[2]),   80'(1'b1));
    check("t3_empty",  80'(empty[2]), 80'(1'b1));
    check("t3_nofull", 80'(full[2]),  80'(1'b0));

    // Wrap: 300 one-word packets through ch3 with random interleaved reads
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1, 3, rnd_word(), 1, 0, ($urandom_range(3) != 0), 3);
      if (rd_valid) cnt++;
    end
    for (int i = 0; i < 300; i++) begin
      tick(0, 0, '0, 0, 0, 1, 3);
      if (rd_valid) cnt++;
    end
    idle();
    if (rd_valid) cnt++;
    check("t4_read_count", 80'(cnt), 80'(300));
    check("t4_empty", 80'(empty[3]), 80'(1'b1));

    // Concurrent: write ch0 while reading ch1 every cycle
    for (int i = 0; i < 64; i++) tick(1, 1, rnd_word(), (i % 8 == 7), 0, 0, 0);
    idle();
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1, 0, rnd_word(), (i % 8 == 7), 0, 1, 1);
      if (rd_valid) cnt++;
    end
    idle();
    if (rd_valid) cnt++;
    check("t5_ch1_reads", 80'(cnt), 80'(64));
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick(0, 0, '0, 0, 0, 1, 0);
      if (rd_valid) cnt++;
    end
    idle();
    if (rd_valid) cnt++;
    check("t5_ch0_reads", 80'(cnt), 80'(64));

    // Random traffic on all channels, with a mid-packet reset part way
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      tick(($urandom_range(9) < 6), $urandom_range(3), rnd_word(), ($urandom_range(5) == 0),
           ($urandom_range(39) == 0), ($urandom_range(9) < ((i < 1000) ? 3 : 6)),
           $urandom_range(3));
    end
    idle();
    idle();

`ifdef FIFO_STATS_EN
    // Drop counter: one overflow plus two aborts on ch1
    begin : t6
      logic [63:0] dc;
      do_reset();
      for (int i = 0; i < DEPTH + 1; i++) tick(1, 1, rnd_word(), 0, 0, 0, 0);
      tick(1, 1, rnd_word(), 1, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        tick(1, 1, rnd_word(), 0, 0, 0, 0);
        tick(1, 1, rnd_word(), 0, 0, 0, 0);
        tick(0, 1, '0, 0, 1, 0, 0);
      end
      idle();
      dc = drop_cnt;
      check("t6_ch1_drops", 80'(dc[31:16]), 80'(16'd3));
      check("t6_other_drops", 80'({dc[63:32], dc[15:0]}), 80'(0));
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
